// File: rtl/bennett_op_sequencer.sv
// rtl/bennett_op_sequencer.sv - operand sequencer between the Bennett clock generator and the adiabatic adder
// Holds one add operation on the adder for a full Bennett cycle and buffers results in a 2-entry FIFO.
module bennett_op_sequencer #(
  parameter int WIDTH  = 11,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inst_flag,
  input  logic [WIDTH-1:0]  clkp,
  input  logic [WIDTH-1:0]  clkn,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic              op_cin,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic              alu_cin,
  input  logic [DATA_W-1:0] alu_sum,
  input  logic              alu_cout,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_sum,
  output logic              res_cout,
  output logic              busy,
  output logic              err_phase
);

  typedef enum logic [1:0] {IDLE, WAIT_START, EVAL, HOLD} state_t;

  state_t state, state_next;

  logic              full;
  logic              accept;
  logic              push;
  logic              pop;
  logic              err_set;
  logic [DATA_W:0]   fifo_mem [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        count;

  // Case equality so that a floating (X) rail never counts as asserted.
  assign full = (clkp === {WIDTH{1'b1}}) && (clkn === {WIDTH{1'b0}});

  assign op_ready  = (state == IDLE) && (count < 2'd2);
  assign accept    = op_valid && op_ready;
  assign res_valid = (count != 2'd0);
  assign pop       = res_valid && res_ready;
  assign res_sum   = res_valid ? fifo_mem[rd_ptr][DATA_W-1:0] : '0;
  assign res_cout  = res_valid ? fifo_mem[rd_ptr][DATA_W] : 1'b0;

  always_comb begin
    state_next = state;
    push       = 1'b0;
    err_set    = 1'b0;
    case (state)
      IDLE:       if (accept) state_next = WAIT_START;
      WAIT_START: if (inst_flag) state_next = EVAL;
      EVAL: begin
        if (full) begin
          push       = 1'b1;
          state_next = HOLD;
        end else if (inst_flag) begin
          err_set = 1'b1;
        end
      end
      HOLD:       if (inst_flag) state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      err_phase <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_cin   <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next != IDLE);
      if (err_set) err_phase <= 1'b1;
      if (accept) begin
        alu_a   <= op_a;
        alu_b   <= op_b;
        alu_cin <= op_cin;
      end else if (state == HOLD && inst_flag) begin
        alu_a   <= '0;
        alu_b   <= '0;
        alu_cin <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      count       <= 2'd0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= {alu_cout, alu_sum};
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule
